alu_seq: RTL and testbench

Registered, parametrised arithmetic logic unit for the datapath. It keeps the existing 8-bit opcode map and adds four things:
- configurable data width;
- a valid/ready handshake on both sides;
- carry and overflow flags computed from the result;
- an optional iterative multiplier.

It sits between the control unit (which issues opcode and operands) and the accumulator write-back path. It replaces the purely combinational ALU.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_mul_iter.sv | 62 ++++++
 rtl/alu_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, FSM state encoding, flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro: ALU_MUL_EN (adds the MUL state).
package alu_pkg;

  // Opcode map, shared with the control unit.
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDM   = 8'h01;
  localparam logic [7:0] OP_LDV   = 8'h02;
  localparam logic [7:0] OP_STORE = 8'h03;
  localparam logic [7:0] OP_CLR   = 8'h04;
  localparam logic [7:0] OP_ADDM  = 8'h05;
  localparam logic [7:0] OP_ADDV  = 8'h06;
  localparam logic [7:0] OP_SUBM  = 8'h07;
  localparam logic [7:0] OP_SUBV  = 8'h08;
  localparam logic [7:0] OP_NEGM  = 8'h09;
  localparam logic [7:0] OP_NOTM  = 8'h0A;
  localparam logic [7:0] OP_AND   = 8'h0B;
  localparam logic [7:0] OP_OR    = 8'h0C;
  localparam logic [7:0] OP_XOR   = 8'h0D;
  localparam logic [7:0] OP_SHL   = 8'h0E;
  localparam logic [7:0] OP_SHR   = 8'h0F;
  localparam logic [7:0] OP_JMP   = 8'h10;
  localparam logic [7:0] OP_JZ    = 8'h11;
  localparam logic [7:0] OP_JN    = 8'h12;
  localparam logic [7:0] OP_JC    = 8'h13;
  localparam logic [7:0] OP_JV    = 8'h14;
  localparam logic [7:0] OP_MUL   = 8'h15;
  localparam logic [7:0] OP_ROL   = 8'h16;

  // Control FSM states; MUL only exists when the multiplier is built.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    MUL  = 2'd2,
`endif
    DONE = 2'd1
  } alu_state_e;

  // Status flags that travel with every result.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  // Flag value while no result has been produced (z == 0).
  localparam alu_flags_t FLAGS_RESET = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: start at edge N, done pulses after edge N+WIDTH with product valid.
// Backpressure: none; product holds until the next start.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, carry/overflow flags, optional multiplier.
// Latency: 1 cycle from accept to out_valid; multiply (ALU_MUL_EN) takes WIDTH+1 cycles.
// Backpressure: result and flags hold while out_valid && !out_ready; no accept until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] mdr,
  input  logic [WIDTH-1:0] ac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zflag,
  output logic             nflag,
  output logic             cflag,
  output logic             vflag,
  output logic             illegal
);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_z;
  alu_flags_t       r_flags;
  logic             r_illegal;

  logic             w_load_alu;
  logic             w_in_ready;
  logic             w_out_valid;

  // Combinational decode operands and intermediate results.
  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_arith_a;
  logic [WIDTH-1:0]   w_arith_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [2*WIDTH-1:0] w_rol2;
  logic               w_add_v;
  logic               w_sub_v;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_ill;

  assign w_sh = value[SHW-1:0];

  // Immediate-operand forms use value; memory forms use mdr; negate subtracts from zero.
  assign w_arith_a = (opcode == OP_NEGM) ? '0 : ac;
  assign w_arith_b = (opcode == OP_ADDV || opcode == OP_SUBV) ? value : mdr;

  // One extra bit on the left catches carry/borrow out of the MSB.
  assign w_sum  = {1'b0, w_arith_a} + {1'b0, w_arith_b};
  assign w_diff = {1'b0, w_arith_a} - {1'b0, w_arith_b};

  // Overflow: same-sign add changes sign; different-sign subtract changes minuend's sign.
  assign w_add_v = (w_arith_a[WIDTH-1] == w_arith_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != w_arith_a[WIDTH-1]);
  assign w_sub_v = (w_arith_a[WIDTH-1] != w_arith_b[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != w_arith_a[WIDTH-1]);

  // Guard bits on either side keep the last shifted-out bit (0 for a zero shift).
  assign w_shl  = {1'b0, ac} << w_sh;
  assign w_shr  = {ac, 1'b0} >> w_sh;
  // Upper half of a doubled operand shifted left is the left rotation.
  assign w_rol2 = {ac, ac} << w_sh;

  // Opcode decode: result, carry, overflow and illegal for single-cycle operations.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (opcode)
      OP_LDM: w_res = mdr;
      OP_LDV: w_res = value;
      OP_CLR: w_res = '0;
      OP_ADDM, OP_ADDV: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      OP_SUBM, OP_SUBV, OP_NEGM: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_v;
      end
      OP_NOTM: w_res = ~mdr;
      OP_AND:  w_res = ac & mdr;
      OP_OR:   w_res = ac | mdr;
      OP_XOR:  w_res = ac ^ mdr;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_ROL: w_res = w_rol2[2*WIDTH-1:WIDTH];
      OP_NOP, OP_STORE, OP_JMP, OP_JZ, OP_JN, OP_JC, OP_JV: w_res = ac;
`ifdef ALU_MUL_EN
      // Result comes from the iterative multiplier, not from this decode.
      OP_MUL: w_res = '0;
`endif
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic               w_mul_start;
  logic               w_load_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (ac),
    .b       (mdr),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );
`endif

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control FSM next state, handshake outputs and result-load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_alu  = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
`ifdef ALU_MUL_EN
    w_mul_start = 1'b0;
    w_load_mul  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (opcode == OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = MUL;
          end else begin
            w_load_alu  = 1'b1;
            w_state_nxt = DONE;
          end
`else
          w_load_alu  = 1'b1;
          w_state_nxt = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (w_mul_done && !w_mul_busy) begin
          w_load_mul  = 1'b1;
          w_state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result and flag registers: loaded once per operation, held through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z       <= '0;
      r_flags   <= FLAGS_RESET;
      r_illegal <= 1'b0;
    end else if (w_load_alu) begin
      r_z       <= w_res;
      r_flags   <= '{z: (w_res == '0), n: w_res[WIDTH-1], c: w_c, v: w_v};
      r_illegal <= w_ill;
    end
`ifdef ALU_MUL_EN
    else if (w_load_mul) begin
      r_z       <= w_mul_prod[WIDTH-1:0];
      r_flags   <= '{z: (w_mul_prod[WIDTH-1:0] == '0),
                     n: w_mul_prod[WIDTH-1],
                     c: (|w_mul_prod[2*WIDTH-1:WIDTH]),
                     v: 1'b0};
      r_illegal <= 1'b0;
    end
`endif
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign z         = r_z;
  assign zflag     = r_flags.z;
  assign nflag     = r_flags.n;
  assign cflag     = r_flags.c;
  assign vflag     = r_flags.v;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
// Latency: checks 1-cycle results and, under ALU_MUL_EN, 9-cycle multiplies.
// Backpressure: holds out_ready low and checks result stability and request holding.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   opcode;
  logic [W-1:0] value;
  logic [W-1:0] mdr;
  logic [W-1:0] ac;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         zflag;
  logic         nflag;
  logic         cflag;
  logic         vflag;
  logic         illegal;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .value     (value),
    .mdr       (mdr),
    .ac        (ac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zflag     (zflag),
    .nflag     (nflag),
    .cflag     (cflag),
    .vflag     (vflag),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {zflag, nflag, cflag, vflag, illegal}.
  function automatic logic [31:0] flags_now();
    return {27'd0, zflag, nflag, cflag, vflag, illegal};
  endfunction

  // Present one request, scramble operands after accept, wait for the result and check it.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] m, input logic [7:0] v, input int lat,
                        input logic [7:0] ez, input logic [4:0] ef);
    int n;
    @(negedge clk);
    opcode = op; ac = a; mdr = m; value = v; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opcode = 8'hFF; ac = 8'hA5; mdr = 8'h5A; value = 8'hC3;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".z"}, 32'(z), 32'(ez));
    chk({tag, ".flags"}, flags_now(), 32'(ef));
    chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Consume the pending result and check the handshake returns to idle.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; value = '0; mdr = '0; ac = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.z", 32'(z), 32'h00);
    chk("reset.flags", flags_now(), 32'b10000);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Single-cycle arithmetic, logic and shifts
    run_op("add_ovf", 8'h05, 8'h7F, 8'h01, 8'h00, 1, 8'h80, 5'b01010); consume("add_ovf");
    run_op("subv_borrow", 8'h08, 8'h00, 8'h00, 8'h01, 1, 8'hFF, 5'b01100); consume("subv_borrow");
    run_op("shl", 8'h0E, 8'h81, 8'h00, 8'h09, 1, 8'h02, 5'b00100); consume("shl");
    run_op("shr", 8'h0F, 8'h03, 8'h00, 8'h02, 1, 8'h00, 5'b10100); consume("shr");
    run_op("subm_ovf", 8'h07, 8'h80, 8'h01, 8'h00, 1, 8'h7F, 5'b00010); consume("subm_ovf");
    run_op("neg", 8'h09, 8'h12, 8'h80, 8'h00, 1, 8'h80, 5'b01110); consume("neg");
    run_op("rol", 8'h16, 8'h81, 8'h00, 8'h01, 1, 8'h03, 5'b00000); consume("rol");
    run_op("jmp_pass", 8'h10, 8'h5A, 8'h00, 8'h00, 1, 8'h5A, 5'b00000); consume("jmp_pass");
    run_op("and", 8'h0B, 8'hF0, 8'h3C, 8'h00, 1, 8'h30, 5'b00000); consume("and");
    run_op("or", 8'h0C, 8'hF0, 8'h3C, 8'h00, 1, 8'hFC, 5'b01000); consume("or");
    run_op("not", 8'h0A, 8'h00, 8'h0F, 8'h00, 1, 8'hF0, 5'b01000); consume("not");
    run_op("illegal", 8'h20, 8'h77, 8'h11, 8'h22, 1, 8'h00, 5'b10001); consume("illegal");

    // Multiply (or unmapped opcode when the multiplier is not built)
`ifdef ALU_MUL_EN
    run_op("mul_ff", 8'h15, 8'h0F, 8'h11, 8'h00, MUL_LAT, 8'hFF, 5'b01000); consume("mul_ff");
    run_op("mul_ovf", 8'h15, 8'h10, 8'h10, 8'h00, MUL_LAT, 8'h00, 5'b10100); consume("mul_ovf");
`else
    run_op("mul_ff", 8'h15, 8'h0F, 8'h11, 8'h00, MUL_LAT, 8'h00, 5'b10001); consume("mul_ff");
    run_op("mul_ovf", 8'h15, 8'h10, 8'h10, 8'h00, MUL_LAT, 8'h00, 5'b10001); consume("mul_ovf");
`endif

    // Backpressure: result holds, a request presented meanwhile waits until idle
    run_op("bp", 8'h06, 8'hFF, 8'h00, 8'h01, 1, 8'h00, 5'b10100);
    opcode = 8'h02; value = 8'h77; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold_z", 32'(z), 32'h00);
      chk("bp.hold_flags", flags_now(), 32'b10100);
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
    end
    consume("bp");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.held_req_valid", 32'(out_valid), 32'd1);
    chk("bp.held_req_z", 32'(z), 32'h77);
    consume("bp_req");

    // Reset part-way through an operation: result is lost
    run_op("pre_rst", 8'h02, 8'h00, 8'h00, 8'h33, 1, 8'h33, 5'b00000); consume("pre_rst");
    @(negedge clk);
    opcode = 8'h15; ac = 8'h03; mdr = 8'h05; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.z", 32'(z), 32'h00);
    chk("rst_mid.zflag", 32'(zflag), 32'd1);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("rst_mid.result_lost", 32'(seen_valid), 32'd0);

    // Operation resumes normally after reset
    run_op("xor_after_rst", 8'h0D, 8'hF0, 8'hFF, 8'h00, 1, 8'h0F, 5'b00000); consume("xor_after_rst");
    run_op("clr", 8'h04, 8'h99, 8'h00, 8'h00, 1, 8'h00, 5'b10000); consume("clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
